// File: rtl/arb_pkg.sv
// Shared types and the round-robin pick function for the 16-way arbiter.
package arb_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // First set request bit found scanning upward from ptr, wrapping at N_REQ.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + k[SEL_W-1:0];
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/onehot_dec4x16.sv
// Combinational 4-to-16 one-hot decoder; all-zero output while disabled.
module onehot_dec4x16
    import arb_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_en,
    output logic [N_REQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (sel_en) begin
            gnt[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin owner selection for a shared decoded resource with hold timeout.
module rr_arbiter16
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 64,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        rel,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        sel_en,
    output logic        busy,
    output logic        timeout
);

    arb_state_t        state;
    logic [SEL_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt;
    logic              timeout_q;

    logic [SEL_W-1:0]  winner;
    logic              hold_done;
    logic              grant_end;

    assign winner    = rr_pick(req, ptr);
    assign hold_done = (cnt == CNT_W'(MAX_HOLD));
    assign grant_end = rel || !req[sel] || hold_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (|req) begin
                        sel   <= winner;
                        cnt   <= CNT_W'(1);
                        state <= GRANT;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        state     <= GAP;
                        ptr       <= sel + 1'b1;
                        cnt       <= '0;
                        // A release or a dropped request wins over a coincident expiry.
                        timeout_q <= hold_done && !rel && req[sel];
                    end else if (!hold_done) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sel_en  = (state == GRANT);
    assign busy    = (state != IDLE);
    assign timeout = timeout_q;

    onehot_dec4x16 u_dec (
        .sel    (sel),
        .sel_en (sel_en),
        .gnt    (gnt)
    );

endmodule
